// File: rtl/layer2_mac_pkg.sv
// layer2_mac_pkg
// Shared definitions for the second-layer multiply-accumulate block:
// default data format (Q8.8), layer dimensions, FSM state encoding and a
// reference round/saturate function at the default widths.
package layer2_mac_pkg;

  localparam int DW       = 16;         // signed data width
  localparam int FRAC     = 8;          // fractional bits
  localparam int N_HIDDEN = 10;         // activations per dot product
  localparam int N_OUT    = 10;         // output neurons
  localparam int AW       = 2*DW + 4;   // accumulator width (headroom for 16 products)

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    EMIT  = 2'd3
  } state_t;

  // Round half up, arithmetic shift down by FRAC, clamp to the DW range.
  function automatic logic [DW-1:0] sat_round(input logic signed [AW-1:0] acc);
    logic signed [AW:0] rounded;
    logic signed [AW:0] shifted;
    logic signed [AW:0] sat_max;
    logic signed [AW:0] sat_min;
    sat_max = $signed({{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}});
    sat_min = $signed({{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}});
    rounded = $signed({acc[AW-1], acc}) + $signed({{(AW+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}});
    shifted = rounded >>> FRAC;
    if (shifted > sat_max) begin
      sat_round = {1'b0, {(DW-1){1'b1}}};
    end else if (shifted < sat_min) begin
      sat_round = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_round = shifted[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/layer2_mac_sat_round.sv
// l2_sat_round
// Combinational rounding and saturation of the wide dot-product
// accumulator down to a DW-bit fixed-point result.
// Ports:
//   acc    in  2*DW+4  signed accumulator, 2*FRAC fractional bits
//   result out DW      round-half-up, shifted, clamped result (FRAC frac bits)
module l2_sat_round
  import layer2_mac_pkg::*;
#(
  parameter int DW   = layer2_mac_pkg::DW,
  parameter int FRAC = layer2_mac_pkg::FRAC
) (
  input  logic signed [2*DW+3:0] acc,
  output logic        [DW-1:0]   result
);

  localparam int AW = 2*DW + 4;

  // One extra bit so the rounding constant can never wrap the sum.
  localparam logic signed [AW:0] ROUND   = $signed({{(AW+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}});
  localparam logic signed [AW:0] SAT_MAX = $signed({{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [AW:0] SAT_MIN = $signed({{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}});

  logic signed [AW:0] rounded;
  logic signed [AW:0] shifted;

  assign rounded = $signed({acc[AW-1], acc}) + ROUND;
  assign shifted = rounded >>> FRAC;

  always_comb begin
    result = shifted[DW-1:0];
    if (shifted > SAT_MAX) begin
      result = {1'b0, {(DW-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      result = {1'b1, {(DW-1){1'b0}}};
    end
  end

endmodule

// File: rtl/layer2_mac.sv
// layer2_mac
// Second neural-network layer: buffers N_HIDDEN hidden activations, then
// for each of N_OUT output neurons streams one weight row from an external
// SRAM (1-cycle read latency), accumulates the dot product and emits a
// rounded, saturated result.
// Ports:
//   clk        in   clock, all state on rising edge
//   reset      in   asynchronous active-low reset
//   act_valid  in   activation present on act_data
//   act_data   in   DW  signed hidden activation
//   act_ready  out  activation accepted this cycle (LOAD only)
//   w_rd       out  weight SRAM read strobe
//   w_addr     out  8   {row[3:0], k[3:0]}
//   w_data     in   DW  weight, valid one cycle after w_rd
//   res_valid  out  one-cycle pulse, m2result/res_row valid
//   res_row    out  4   output neuron index
//   m2result   out  DW  rounded, saturated dot product (held between pulses)
//   done       out  one-cycle pulse with the last row's result
//   busy       out  high outside LOAD
module layer2_mac
  import layer2_mac_pkg::*;
#(
  parameter int N_HIDDEN = layer2_mac_pkg::N_HIDDEN,
  parameter int N_OUT    = layer2_mac_pkg::N_OUT,
  parameter int DW       = layer2_mac_pkg::DW,
  parameter int FRAC     = layer2_mac_pkg::FRAC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          act_valid,
  input  logic [DW-1:0] act_data,
  output logic          act_ready,
  output logic          w_rd,
  output logic [7:0]    w_addr,
  input  logic [DW-1:0] w_data,
  output logic          res_valid,
  output logic [3:0]    res_row,
  output logic [DW-1:0] m2result,
  output logic          done,
  output logic          busy
);

  localparam int AW = 2*DW + 4;

  state_t                state_reg, state_next;
  logic [3:0]            cnt_reg;
  logic [3:0]            row_reg;
  logic [3:0]            k_reg;
  logic                  mac_v_reg;      // a product is due this cycle
  logic signed [DW-1:0]  act_q_reg;      // buffer entry paired with w_data
  logic signed [AW-1:0]  acc_reg;
  logic [DW-1:0]         m2result_reg;
  logic [3:0]            res_row_reg;
  logic                  res_valid_reg;
  logic                  done_reg;

  logic [DW-1:0]         act_buf [N_HIDDEN];

  logic                  accept;
  logic                  last_act;
  logic                  last_k;
  logic                  last_row;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]  acc_sum;
  logic [DW-1:0]         sat_val;

  assign accept   = (state_reg == LOAD) && act_valid;
  assign last_act = (cnt_reg == 4'(N_HIDDEN-1));
  assign last_k   = (k_reg   == 4'(N_HIDDEN-1));
  assign last_row = (row_reg == 4'(N_OUT-1));

  assign prod    = act_q_reg * $signed(w_data);
  assign acc_sum = acc_reg + {{(AW-2*DW){prod[2*DW-1]}}, prod};

  // --- FSM: state register ---
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  // --- FSM: next state and control outputs ---
  always_comb begin
    state_next = state_reg;
    act_ready  = 1'b0;
    w_rd       = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      LOAD: begin
        act_ready = 1'b1;
        busy      = 1'b0;
        if (act_valid && last_act) state_next = MAC;
      end
      MAC: begin
        w_rd = 1'b1;
        if (last_k) state_next = DRAIN;
      end
      DRAIN: state_next = EMIT;
      EMIT:  state_next = last_row ? LOAD : MAC;
      default: state_next = LOAD;
    endcase
  end

  assign w_addr = w_rd ? {row_reg, k_reg} : 8'h00;

  // --- activation buffer: written in LOAD, read registered so the entry
  // lines up with the weight arriving one cycle after w_rd ---
  always_ff @(posedge clk) begin
    if (accept) act_buf[cnt_reg] <= act_data;
    if (w_rd)   act_q_reg        <= $signed(act_buf[k_reg]);
  end

  // --- counters, accumulator and result registers ---
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg       <= 4'd0;
      row_reg       <= 4'd0;
      k_reg         <= 4'd0;
      mac_v_reg     <= 1'b0;
      acc_reg       <= '0;
      m2result_reg  <= '0;
      res_row_reg   <= 4'd0;
      res_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      res_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      mac_v_reg     <= w_rd;
      if (mac_v_reg) acc_reg <= acc_sum;
      case (state_reg)
        LOAD: begin
          if (accept) begin
            cnt_reg <= cnt_reg + 4'd1;
            if (last_act) begin
              row_reg <= 4'd0;
              k_reg   <= 4'd0;
              acc_reg <= '0;
            end
          end
        end
        MAC: begin
          k_reg <= last_k ? 4'd0 : k_reg + 4'd1;
        end
        DRAIN: begin
          // The final product is folded in here, so the result is
          // registered on this edge and presented during EMIT.
          m2result_reg  <= sat_val;
          res_row_reg   <= row_reg;
          res_valid_reg <= 1'b1;
          done_reg      <= last_row;
        end
        EMIT: begin
          acc_reg <= '0;
          k_reg   <= 4'd0;
          if (last_row) begin
            row_reg <= 4'd0;
            cnt_reg <= 4'd0;
          end else begin
            row_reg <= row_reg + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  l2_sat_round #(
    .DW   (DW),
    .FRAC (FRAC)
  ) u_sat_round (
    .acc    (acc_sum),
    .result (sat_val)
  );

  assign m2result  = m2result_reg;
  assign res_row   = res_row_reg;
  assign res_valid = res_valid_reg;
  assign done      = done_reg;

endmodule
